mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS-subset CPU. It replaces the single-cycle decode with a state machine that takes `op`/`func` from the datapath instruction register and drives the datapath strobes (`PCWr`, `IRWr`, `RegWr`, `MemWr`, `Branch`, `Jump`, `RegDst`, `ALUSrc`, `MemtoReg`, `Extop`, `ALUctr`) one phase per cycle. A shared memory port serves fetch and data access, and this block also sequences that port's handshake.

---
 rtl/mc_pkg.sv | 39 +++
 rtl/mc_decode.sv | 40 ++++
 rtl/mc_ctrl.sv | 130 +++++++++++++
 tb/tb_mc_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle control sequencer.
// Contents: FSM state enum, instruction-class enum, opcode/func encodings, ALUctr codes.
package mc_pkg;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_STOREB, C_BEQ, C_J, C_JAL, C_JR, C_JALR, C_BAD
    } cls_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;
    localparam logic [4:0] ALU_SLL = 5'd5;
    localparam logic [4:0] ALU_LUI = 6'd6;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational op/func decoder producing instruction class and ALU code.
// Ports: op, func (in 6 each); cls (out 4, an mc_pkg::cls_t value); aluctr (out 5).
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [3:0] cls,
    output logic [4:0] aluctr
);

    always_comb begin
        cls    = C_BAD;
        aluctr = ALU_ADD;
        case (op)
            OP_R: case (func)
                F_ADDU: cls = C_R;
                F_SUBU: begin cls = C_R; aluctr = ALU_SUB; end
                F_AND:  begin cls = C_R; aluctr = ALU_AND; end
                F_OR:   begin cls = C_R; aluctr = ALU_OR; end
                F_SLT:  begin cls = C_R; aluctr = ALU_SLT; end
                F_SLL:  begin cls = C_R; aluctr = ALU_SLL; end
                F_JR:   cls = C_JR;
                F_JALR: cls = C_JALR;
                default: cls = C_BAD;
            endcase
            OP_ADDIU: cls = C_IALU;
            OP_ORI:   begin cls = C_IALU; aluctr = ALU_OR; end
            OP_LUI:   begin cls = C_IALU; aluctr = ALU_LUI; end
            OP_LW:    cls = C_LOAD;
            OP_SW:    cls = C_STORE;
            OP_SB:    cls = C_STOREB;
            OP_BEQ:   begin cls = C_BEQ; aluctr = ALU_SUB; end
            OP_J:     cls = C_J;
            OP_JAL:   cls = C_JAL;
            default:  cls = C_BAD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM (IF/ID/EX/MEM/WB/HALT) driving datapath strobes.
// Ports: clk, reset (async, active-low), op, func, zero, mem_ready in;
//        PCWr, IRWr, MemRd, MemWr, RegWr, Branch, Jump, RegDst, ALUSrc, MemtoReg,
//        Extop, ALUctr[4:0], retire, halted out.
// Option MC_CTRL_MEM_WAIT_EN: S_IF and S_MEM stall until mem_ready; otherwise mem_ready is ignored.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       RegWr,
    output logic       Branch,
    output logic       Jump,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       Extop,
    output logic [4:0] ALUctr,
    output logic       retire,
    output logic       halted
);

    state_t     state, state_n;
    cls_t       cls_q, cls_d;
    logic [3:0] dec_cls;
    logic [4:0] dec_alu, alu_q;
    logic       rdy, mem_cls;

    mc_decode u_dec (.op(op), .func(func), .cls(dec_cls), .aluctr(dec_alu));

    assign cls_d   = cls_t'(dec_cls);
    assign mem_cls = cls_q inside {C_LOAD, C_STORE, C_STOREB};

`ifdef MC_CTRL_MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IF;
            cls_q <= C_BAD;
            alu_q <= ALU_ADD;
        end else begin
            state <= state_n;
            if (state == S_ID) begin
                cls_q <= cls_d;
                alu_q <= dec_alu;
            end
        end
    end

    // Outputs are gated by reset so nothing strobes while it is held low.
    always_comb begin
        state_n = state;
        {PCWr, IRWr, MemRd, MemWr, RegWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, Extop, retire, halted} = '0;
        ALUctr = '0;
        if (reset) begin
            // Selects come from the registered class, so they stay put from EX through WB.
            if (state inside {S_EX, S_MEM, S_WB}) begin
                RegDst = cls_q == C_R;
                ALUSrc = mem_cls || cls_q == C_IALU;
                Extop  = mem_cls || (cls_q == C_IALU && alu_q == ALU_ADD);
                ALUctr = alu_q;
            end
            case (state)
                S_IF: begin
                    MemRd   = 1'b1;
                    IRWr    = rdy;
                    PCWr    = rdy;
                    state_n = rdy ? S_ID : S_IF;
                end
                S_ID: case (cls_d)
                    C_J, C_JAL: begin
                        Jump    = 1'b1;
                        PCWr    = 1'b1;
                        RegWr   = cls_d == C_JAL;
                        retire  = 1'b1;
                        state_n = S_IF;
                    end
                    C_BAD:   state_n = S_HALT;
                    default: state_n = S_EX;
                endcase
                S_EX: case (cls_q)
                    C_BEQ: begin
                        Branch  = 1'b1;
                        PCWr    = zero;
                        retire  = 1'b1;
                        state_n = S_IF;
                    end
                    C_JR, C_JALR: begin
                        Jump    = 1'b1;
                        PCWr    = 1'b1;
                        RegWr   = cls_q == C_JALR;
                        retire  = 1'b1;
                        state_n = S_IF;
                    end
                    C_LOAD, C_STORE, C_STOREB: state_n = S_MEM;
                    default: state_n = S_WB;
                endcase
                S_MEM: begin
                    MemRd   = cls_q == C_LOAD;
                    MemWr   = cls_q != C_LOAD;
                    retire  = rdy && cls_q != C_LOAD;
                    state_n = !rdy ? S_MEM : cls_q == C_LOAD ? S_WB : S_IF;
                end
                S_WB: begin
                    RegWr    = 1'b1;
                    MemtoReg = cls_q == C_LOAD;
                    retire   = 1'b1;
                    state_n  = S_IF;
                end
                S_HALT: halted = 1'b1;
                default: state_n = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, table-driven self-checking bench for mc_ctrl.
module tb_mc_ctrl;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] op, func;
    logic       PCWr, IRWr, MemRd, MemWr, RegWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, Extop, retire, halted;
    logic [4:0] ALUctr;
    logic [17:0] outs;
    int checks = 0;
    int failures = 0;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr),
        .Branch(Branch), .Jump(Jump), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .Extop(Extop), .ALUctr(ALUctr), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    assign outs = {PCWr, IRWr, MemRd, MemWr, RegWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, Extop, ALUctr, retire, halted};

    localparam logic [17:0] PCW  = 18'd1 << 17;
    localparam logic [17:0] IRW  = 18'd1 << 16;
    localparam logic [17:0] MRD  = 18'd1 << 15;
    localparam logic [17:0] MWR  = 18'd1 << 14;
    localparam logic [17:0] RGW  = 18'd1 << 13;
    localparam logic [17:0] BR   = 18'd1 << 12;
    localparam logic [17:0] JMP  = 18'd1 << 11;
    localparam logic [17:0] RDST = 18'd1 << 10;
    localparam logic [17:0] ASRC = 18'd1 << 9;
    localparam logic [17:0] M2R  = 18'd1 << 8;
    localparam logic [17:0] EXT  = 18'd1 << 7;
    localparam logic [17:0] RET  = 18'd1 << 1;
    localparam logic [17:0] HLT  = 18'd1;
    localparam logic [17:0] IFS  = PCW | IRW | MRD;
    localparam logic [17:0] NONE = 18'd0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, SB = 6'b101000, BEQ = 6'b000100;
    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADDIU = 6'b001001, ORI = 6'b001101;
    localparam logic [5:0] LUI = 6'b001111, RT = 6'b000000, BAD = 6'b111111;

    function automatic logic [17:0] A(input int n);
        return 18'(n) << 2;
    endfunction

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic [17:0] exp;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input logic [17:0] e);
        tv.push_back('{op: o, func: f, zero: z, exp: e});
    endtask

    task automatic chk(input string nm, input logic [17:0] exp);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", nm, outs, exp);
        end
    endtask

    task automatic step(input string nm, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic m, input logic [17:0] exp);
        op = o; func = f; zero = z; mem_ready = m;
        @(negedge clk);
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        clk = 0; reset = 0; op = LW; func = 0; zero = 0; mem_ready = 1;

        // lw: IF ID EX MEM WB
        add(LW, 0, 0, IFS); add(LW, 0, 0, NONE); add(LW, 0, 0, ASRC | EXT);
        add(LW, 0, 0, MRD | ASRC | EXT); add(LW, 0, 0, RGW | M2R | ASRC | EXT | RET);
        // beq taken, then not taken
        add(BEQ, 0, 1, IFS); add(BEQ, 0, 1, NONE); add(BEQ, 0, 1, BR | PCW | RET | A(1));
        add(BEQ, 0, 0, IFS); add(BEQ, 0, 0, NONE); add(BEQ, 0, 0, BR | RET | A(1));
        // jal then addu
        add(JAL, 0, 0, IFS); add(JAL, 0, 0, JMP | PCW | RGW | RET);
        add(RT, 6'b100001, 0, IFS); add(RT, 6'b100001, 0, NONE);
        add(RT, 6'b100001, 0, RDST); add(RT, 6'b100001, 0, RDST | RGW | RET);
        // subu, sll
        add(RT, 6'b100011, 0, IFS); add(RT, 6'b100011, 0, NONE);
        add(RT, 6'b100011, 0, RDST | A(1)); add(RT, 6'b100011, 0, RDST | A(1) | RGW | RET);
        add(RT, 6'b000000, 0, IFS); add(RT, 6'b000000, 0, NONE);
        add(RT, 6'b000000, 0, RDST | A(5)); add(RT, 6'b000000, 0, RDST | A(5) | RGW | RET);
        // ori, addiu, lui
        add(ORI, 0, 0, IFS); add(ORI, 0, 0, NONE);
        add(ORI, 0, 0, ASRC | A(3)); add(ORI, 0, 0, ASRC | A(3) | RGW | RET);
        add(ADDIU, 0, 0, IFS); add(ADDIU, 0, 0, NONE);
        add(ADDIU, 0, 0, ASRC | EXT); add(ADDIU, 0, 0, ASRC | EXT | RGW | RET);
        add(LUI, 0, 0, IFS); add(LUI, 0, 0, NONE);
        add(LUI, 0, 0, ASRC | A(6)); add(LUI, 0, 0, ASRC | A(6) | RGW | RET);
        // sw, sb
        add(SW, 0, 0, IFS); add(SW, 0, 0, NONE); add(SW, 0, 0, ASRC | EXT);
        add(SW, 0, 0, MWR | ASRC | EXT | RET);
        add(SB, 0, 0, IFS); add(SB, 0, 0, NONE); add(SB, 0, 0, ASRC | EXT);
        add(SB, 0, 0, MWR | ASRC | EXT | RET);
        // j, jr, jalr
        add(J, 0, 0, IFS); add(J, 0, 0, JMP | PCW | RET);
        add(RT, 6'b001000, 0, IFS); add(RT, 6'b001000, 0, NONE); add(RT, 6'b001000, 0, JMP | PCW | RET);
        add(RT, 6'b001001, 0, IFS); add(RT, 6'b001001, 0, NONE); add(RT, 6'b001001, 0, JMP | PCW | RGW | RET);
        // unsupported op halts from cycle 3 and stays
        add(BAD, 0, 0, IFS); add(BAD, 0, 0, NONE); add(BAD, 0, 0, HLT);
        add(BAD, 0, 0, HLT); add(BAD, 0, 0, HLT);

        @(posedge clk);
        @(negedge clk);
        chk("reset_state", NONE);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < tv.size(); i++)
            step($sformatf("vec%0d", i), tv[i].op, tv[i].func, tv[i].zero, 1'b1, tv[i].exp);

        // reset pulse leaves halt; outputs forced low while reset is low
        reset = 1'b0;
        #1;
        chk("halt_reset_low", NONE);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("resume_if", LW, 0, 0, 1, IFS);
        step("resume_id", LW, 0, 0, 1, NONE);

        // reset during S_MEM of sw aborts the store
        do_reset();
        step("abort_sw_if", SW, 0, 0, 1, IFS);
        step("abort_sw_id", SW, 0, 0, 1, NONE);
        step("abort_sw_ex", SW, 0, 0, 1, ASRC | EXT);
        @(negedge clk);
        chk("abort_sw_mem", MWR | ASRC | EXT | RET);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_async_low", NONE);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("abort_if", SW, 0, 0, 1, IFS);
        step("abort_id", SW, 0, 0, 1, NONE);

        do_reset();
`ifdef MC_CTRL_MEM_WAIT_EN
        step("w_if_hold", SW, 0, 0, 0, MRD);
        step("w_if_rdy", SW, 0, 0, 1, IFS);
        step("w_id", SW, 0, 0, 1, NONE);
        step("w_ex", SW, 0, 0, 1, ASRC | EXT);
        for (int k = 0; k < 3; k++)
            step($sformatf("w_mem_hold%0d", k), SW, 0, 0, 0, MWR | ASRC | EXT);
        step("w_mem_rdy", SW, 0, 0, 1, MWR | ASRC | EXT | RET);
        step("w_next_if", SW, 0, 0, 1, IFS);
`else
        step("nw_if", LW, 0, 0, 0, IFS);
        step("nw_id", LW, 0, 0, 0, NONE);
        step("nw_ex", LW, 0, 0, 0, ASRC | EXT);
        step("nw_mem", LW, 0, 0, 0, MRD | ASRC | EXT);
        step("nw_wb", LW, 0, 0, 0, RGW | M2R | ASRC | EXT | RET);
        step("nw_next_if", LW, 0, 0, 0, IFS);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
